wb_write_arbiter: RTL and testbench

- Owns the single register-file write port and shares it between two requesters:
  - the in-order WB stage (highest priority);
  - the long-latency unit (mult/div result path), through a valid/ready handshake and a small pending FIFO.
- Produces the WB-stage stall needed for starvation relief and for draining pending writes before a syscall.
- Provides a pending-destination lookup for the decode-stage hazard logic.

---
 rtl/wb_write_arbiter.sv | 213 +++++++++++++++++++++
 tb/tb_wb_write_arbiter.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_write_arbiter.sv
// wb_write_arbiter
//   Owns the single register-file write port and shares it between the
//   in-order WB stage (highest priority) and the long-latency unit, which
//   delivers results through a valid/ready handshake into a small pending
//   FIFO.  Raises stall_wb to steal the WB slot for a starved FIFO head and
//   to drain pending writes before a syscall.  Exposes a pending-destination
//   lookup for decode hazard detection.
//
// Ports
//   clk, reset                 clock, synchronous active-high reset
//   regwritew/writeregw/resultw WB-stage write request
//   syscallw                   syscall in WB (triggers drain)
//   lu_valid/lu_reg/lu_data    long-unit result, lu_ready back-pressure
//   lu_busy                    long-unit operation in flight
//   rs_d/rt_d/dst_d            decode lookup registers -> pend_hazard
//   stall_wb                   hold the WB stage (decoded from state)
//   rf_we/rf_wa/rf_wd          registered register-file write port
module wb_write_arbiter #(
    parameter int DEPTH        = 2,
    parameter int STARVE_LIMIT = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        regwritew,
    input  logic [4:0]  writeregw,
    input  logic [31:0] resultw,
    input  logic        syscallw,
    input  logic        lu_valid,
    input  logic [4:0]  lu_reg,
    input  logic [31:0] lu_data,
    input  logic        lu_busy,
    output logic        lu_ready,
    input  logic [4:0]  rs_d,
    input  logic [4:0]  rt_d,
    input  logic [4:0]  dst_d,
    output logic        pend_hazard,
    output logic        stall_wb,
    output logic        rf_we,
    output logic [4:0]  rf_wa,
    output logic [31:0] rf_wd
);

    localparam int AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW   = $clog2(DEPTH + 1);
    localparam int AGEW = $clog2(STARVE_LIMIT + 1);
    localparam logic [CW-1:0]   FULL_CNT  = CW'(DEPTH);
    localparam logic [AGEW-1:0] AGE_LIMIT = AGEW'(STARVE_LIMIT);

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_STEAL = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    state_t            state_r, state_next_s;
    logic [4:0]        fifo_reg_r  [DEPTH];
    logic [31:0]       fifo_data_r [DEPTH];
    logic [DEPTH-1:0]  fifo_vld_r;
    logic [AW-1:0]     rd_ptr_r, wr_ptr_r;
    logic [CW-1:0]     count_r;
    logic [AGEW-1:0]   age_r, age_next_s;

    logic        empty_s, full_s, lu_live_s, wb_busy_s;
    logic        push_s, pop_s, gnt_s;
    logic [4:0]  gnt_wa_s;
    logic [31:0] gnt_wd_s;

    // True when a non-zero register r equals any of the three lookup registers.
    function automatic logic lookup_hit(input logic [4:0] r, input logic [4:0] a,
                                        input logic [4:0] b, input logic [4:0] c);
        return (r != 5'd0) && ((r == a) || (r == b) || (r == c));
    endfunction

    assign empty_s   = (count_r == {CW{1'b0}});
    assign full_s    = (count_r == FULL_CNT);
    // No pass-through when full, even if the head pops this cycle.
    assign lu_ready  = !full_s;
    // Transfers to register 0 complete the handshake but are dropped.
    assign lu_live_s = lu_valid && !full_s && (lu_reg != 5'd0);
    // WB only competes in RUN; in STEAL/DRAIN it is being held.
    assign wb_busy_s = regwritew && (writeregw != 5'd0) && (state_r == ST_RUN);
    assign stall_wb  = (state_r != ST_RUN);

    // Grant selection, FIFO push/pop and next-state decision.
    always_comb begin
        gnt_s        = 1'b0;
        gnt_wa_s     = rf_wa;
        gnt_wd_s     = rf_wd;
        push_s       = 1'b0;
        pop_s        = 1'b0;
        state_next_s = state_r;
        case (state_r)
            ST_RUN: begin
                if (wb_busy_s) begin
                    gnt_s    = 1'b1;
                    gnt_wa_s = writeregw;
                    gnt_wd_s = resultw;
                    push_s   = lu_live_s;
                end else if (!empty_s) begin
                    gnt_s    = 1'b1;
                    pop_s    = 1'b1;
                    gnt_wa_s = fifo_reg_r[rd_ptr_r];
                    gnt_wd_s = fifo_data_r[rd_ptr_r];
                    push_s   = lu_live_s;
                end else if (lu_live_s) begin
                    gnt_s    = 1'b1;
                    gnt_wa_s = lu_reg;
                    gnt_wd_s = lu_data;
                end else begin
                    gnt_s    = 1'b0;
                end
                // Drain beats steal; a head already popped this cycle is not starved.
                if (syscallw && (!empty_s || lu_busy || lu_valid)) begin
                    state_next_s = ST_DRAIN;
                end else if ((age_r == AGE_LIMIT) && !pop_s) begin
                    state_next_s = ST_STEAL;
                end else begin
                    state_next_s = ST_RUN;
                end
            end
            ST_STEAL, ST_DRAIN: begin
                if (!empty_s) begin
                    gnt_s    = 1'b1;
                    pop_s    = 1'b1;
                    gnt_wa_s = fifo_reg_r[rd_ptr_r];
                    gnt_wd_s = fifo_data_r[rd_ptr_r];
                    push_s   = lu_live_s;
                end else if (lu_live_s) begin
                    gnt_s    = 1'b1;
                    gnt_wa_s = lu_reg;
                    gnt_wd_s = lu_data;
                end else begin
                    gnt_s    = 1'b0;
                end
                if (state_r == ST_STEAL) begin
                    state_next_s = ST_RUN;
                end else if (empty_s && !lu_busy && !lu_valid) begin
                    state_next_s = ST_RUN;
                end else begin
                    state_next_s = ST_DRAIN;
                end
            end
            default: begin
                state_next_s = ST_RUN;
            end
        endcase
    end

    // Head age: counts cycles a non-empty FIFO head waits, saturating.
    always_comb begin
        age_next_s = age_r;
        if (empty_s || pop_s) begin
            age_next_s = {AGEW{1'b0}};
        end else if (age_r < AGE_LIMIT) begin
            age_next_s = age_r + {{(AGEW-1){1'b0}}, 1'b1};
        end else begin
            age_next_s = age_r;
        end
    end

    // Pending-destination lookup over valid FIFO entries and the write in flight.
    always_comb begin
        pend_hazard = rf_we && lookup_hit(rf_wa, rs_d, rt_d, dst_d);
        for (int i = 0; i < DEPTH; i++) begin
            if (fifo_vld_r[i] && lookup_hit(fifo_reg_r[i], rs_d, rt_d, dst_d)) begin
                pend_hazard = 1'b1;
            end else begin
                pend_hazard = pend_hazard;
            end
        end
    end

    // State, FIFO storage/pointers, age and registered write port.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r    <= ST_RUN;
            fifo_vld_r <= {DEPTH{1'b0}};
            rd_ptr_r   <= {AW{1'b0}};
            wr_ptr_r   <= {AW{1'b0}};
            count_r    <= {CW{1'b0}};
            age_r      <= {AGEW{1'b0}};
            rf_we      <= 1'b0;
            rf_wa      <= 5'd0;
            rf_wd      <= 32'd0;
            for (int i = 0; i < DEPTH; i++) begin
                fifo_reg_r[i]  <= 5'd0;
                fifo_data_r[i] <= 32'd0;
            end
        end else begin
            state_r <= state_next_s;
            age_r   <= age_next_s;
            rf_we   <= gnt_s;
            rf_wa   <= gnt_wa_s;
            rf_wd   <= gnt_wd_s;
            if (push_s) begin
                fifo_reg_r[wr_ptr_r]  <= lu_reg;
                fifo_data_r[wr_ptr_r] <= lu_data;
                fifo_vld_r[wr_ptr_r]  <= 1'b1;
                wr_ptr_r              <= wr_ptr_r + {{(AW-1){1'b0}}, 1'b1};
            end
            if (pop_s) begin
                fifo_vld_r[rd_ptr_r] <= 1'b0;
                rd_ptr_r             <= rd_ptr_r + {{(AW-1){1'b0}}, 1'b1};
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + {{(CW-1){1'b0}}, 1'b1};
                2'b01:   count_r <= count_r - {{(CW-1){1'b0}}, 1'b1};
                default: count_r <= count_r;
            endcase
        end
    end

endmodule

// File: tb/tb_wb_write_arbiter.sv
module tb_wb_write_arbiter;

    logic        clk, reset;
    logic        regwritew, syscallw, lu_valid, lu_busy, lu_ready;
    logic [4:0]  writeregw, lu_reg, rs_d, rt_d, dst_d, rf_wa;
    logic [31:0] resultw, lu_data, rf_wd;
    logic        pend_hazard, stall_wb, rf_we;

    typedef struct packed {
        logic [4:0]  wa;
        logic [31:0] wd;
    } wr_t;

    wr_t exp_q[$];
    wr_t mon_e;
    int  checks = 0;
    int  errors = 0;

    wb_write_arbiter #(.DEPTH(2), .STARVE_LIMIT(8)) dut (
        .clk(clk), .reset(reset),
        .regwritew(regwritew), .writeregw(writeregw), .resultw(resultw),
        .syscallw(syscallw),
        .lu_valid(lu_valid), .lu_reg(lu_reg), .lu_data(lu_data),
        .lu_busy(lu_busy), .lu_ready(lu_ready),
        .rs_d(rs_d), .rt_d(rt_d), .dst_d(dst_d), .pend_hazard(pend_hazard),
        .stall_wb(stall_wb),
        .rf_we(rf_we), .rf_wa(rf_wa), .rf_wd(rf_wd)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Scoreboard: every register-file write must match the next expected one.
    always @(negedge clk) begin
        if (rf_we === 1'b1) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_write got wa=%0d wd=%h required no write", rf_wa, rf_wd);
            end else begin
                mon_e = exp_q.pop_front();
                if (rf_wa !== mon_e.wa || rf_wd !== mon_e.wd) begin
                    errors++;
                    $display("FAIL write_order got wa=%0d wd=%h required wa=%0d wd=%h",
                             rf_wa, rf_wd, mon_e.wa, mon_e.wd);
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        regwritew = 1'b0; writeregw = 5'd0; resultw = 32'd0; syscallw = 1'b0;
        lu_valid = 1'b0; lu_reg = 5'd0; lu_data = 32'd0; lu_busy = 1'b0;
        rs_d = 5'd0; rt_d = 5'd0; dst_d = 5'd0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        idle_inputs();
        step(); step();
        reset = 1'b0;
        #1;
        checks++;
        if (rf_we !== 1'b0 || rf_wa !== 5'd0 || rf_wd !== 32'd0 || stall_wb !== 1'b0 || lu_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_state got we=%b wa=%0d wd=%h stall=%b rdy=%b required 0 0 0 0 1",
                     rf_we, rf_wa, rf_wd, stall_wb, lu_ready);
        end
        // fill the FIFO behind busy WB writes
        regwritew = 1'b1; writeregw = 5'd1; resultw = 32'hAAAA_0001;
        lu_valid = 1'b1; lu_reg = 5'd7; lu_data = 32'h0000_0707;
        exp_q.push_back({5'd1, 32'hAAAA_0001});
        step();
        resultw = 32'hAAAA_0002; lu_reg = 5'd9; lu_data = 32'h0000_0909;
        exp_q.push_back({5'd1, 32'hAAAA_0002});
        step();
        regwritew = 1'b0; lu_valid = 1'b0; rs_d = 5'd9; rt_d = 5'd7;
        #1;
        checks++;
        if (lu_ready !== 1'b0) begin
            errors++;
            $display("FAIL full_ready got %b required 0", lu_ready);
        end
        checks++;
        if (pend_hazard !== 1'b1) begin
            errors++;
            $display("FAIL full_hazard got %b required 1", pend_hazard);
        end
        reset = 1'b1;
        step();
        checks++;
        if (rf_we !== 1'b0 || rf_wa !== 5'd0 || rf_wd !== 32'd0 || stall_wb !== 1'b0 ||
            lu_ready !== 1'b1 || pend_hazard !== 1'b0) begin
            errors++;
            $display("FAIL reset_flush got we=%b wa=%0d wd=%h stall=%b rdy=%b hz=%b required 0 0 0 0 1 0",
                     rf_we, rf_wa, rf_wd, stall_wb, lu_ready, pend_hazard);
        end
        reset = 1'b0;
        step(); step(); step();
        idle_inputs();
    endtask

    task automatic test_bypass();
        lu_valid = 1'b1; lu_reg = 5'd5; lu_data = 32'h0000_1234;
        #1;
        checks++;
        if (lu_ready !== 1'b1) begin
            errors++;
            $display("FAIL bypass_ready got %b required 1", lu_ready);
        end
        exp_q.push_back({5'd5, 32'h0000_1234});
        step();
        lu_valid = 1'b0;
        checks++;
        if (rf_we !== 1'b1 || rf_wa !== 5'd5 || rf_wd !== 32'h0000_1234) begin
            errors++;
            $display("FAIL bypass_latency got we=%b wa=%0d wd=%h required 1 5 00001234", rf_we, rf_wa, rf_wd);
        end
        step();
        rs_d = 5'd5;
        #1;
        checks++;
        if (rf_we !== 1'b0 || pend_hazard !== 1'b0) begin
            errors++;
            $display("FAIL bypass_not_queued got we=%b hz=%b required 0 0", rf_we, pend_hazard);
        end
        idle_inputs();
    endtask

    task automatic test_starve();
        regwritew = 1'b1; writeregw = 5'd20; resultw = 32'hA000_0000;
        lu_valid = 1'b1; lu_reg = 5'd7; lu_data = 32'h7777_0007;
        exp_q.push_back({5'd20, 32'hA000_0000});
        step();
        resultw = 32'hA000_0001; lu_reg = 5'd9; lu_data = 32'h9999_0009;
        exp_q.push_back({5'd20, 32'hA000_0001});
        step();
        lu_valid = 1'b0;
        for (int k = 2; k <= 21; k++) begin
            resultw = 32'hA000_0000 + 32'(k);
            #1;
            checks++;
            if (stall_wb !== ((k == 10) || (k == 20))) begin
                errors++;
                $display("FAIL starve_stall cycle %0d got %b required %b", k, stall_wb, (k == 10) || (k == 20));
            end
            checks++;
            if (lu_ready !== (k >= 11)) begin
                errors++;
                $display("FAIL starve_ready cycle %0d got %b required %b", k, lu_ready, k >= 11);
            end
            if (k == 11 || k == 21) begin
                checks++;
                if (rf_we !== 1'b1 || rf_wa !== ((k == 11) ? 5'd7 : 5'd9)) begin
                    errors++;
                    $display("FAIL steal_write cycle %0d got we=%b wa=%0d required 1 %0d",
                             k, rf_we, rf_wa, (k == 11) ? 7 : 9);
                end
            end
            if (k == 10) exp_q.push_back({5'd7, 32'h7777_0007});
            else if (k == 20) exp_q.push_back({5'd9, 32'h9999_0009});
            else exp_q.push_back({5'd20, 32'hA000_0000 + 32'(k)});
            step();
        end
        idle_inputs();
        step(); step();
    endtask

    task automatic test_wb_priority();
        regwritew = 1'b1; writeregw = 5'd3; resultw = 32'h3333_3333;
        lu_valid = 1'b1; lu_reg = 5'd4; lu_data = 32'h4444_4444;
        exp_q.push_back({5'd3, 32'h3333_3333});
        step();
        lu_valid = 1'b0; writeregw = 5'd6; resultw = 32'h6666_6666; rs_d = 5'd4;
        #1;
        checks++;
        if (pend_hazard !== 1'b1) begin
            errors++;
            $display("FAIL queued_hazard got %b required 1", pend_hazard);
        end
        exp_q.push_back({5'd6, 32'h6666_6666});
        step();
        regwritew = 1'b0;
        exp_q.push_back({5'd4, 32'h4444_4444});
        step();
        checks++;
        if (rf_we !== 1'b1 || rf_wa !== 5'd4 || pend_hazard !== 1'b1) begin
            errors++;
            $display("FAIL queued_write got we=%b wa=%0d hz=%b required 1 4 1", rf_we, rf_wa, pend_hazard);
        end
        step();
        checks++;
        if (pend_hazard !== 1'b0) begin
            errors++;
            $display("FAIL hazard_clear got %b required 0", pend_hazard);
        end
        idle_inputs();
    endtask

    task automatic test_drain();
        regwritew = 1'b1; writeregw = 5'd11; resultw = 32'hB0B0_0011;
        lu_valid = 1'b1; lu_reg = 5'd12; lu_data = 32'hC0C0_0012;
        exp_q.push_back({5'd11, 32'hB0B0_0011});
        step();
        regwritew = 1'b0; lu_valid = 1'b0; syscallw = 1'b1; lu_busy = 1'b1;
        #1;
        checks++;
        if (stall_wb !== 1'b0) begin
            errors++;
            $display("FAIL drain_entry_stall got %b required 0", stall_wb);
        end
        exp_q.push_back({5'd12, 32'hC0C0_0012});
        for (int c = 2; c <= 6; c++) begin
            step();
            if (c == 4) begin
                lu_busy = 1'b0; lu_valid = 1'b1; lu_reg = 5'd14; lu_data = 32'hD0D0_0014;
                exp_q.push_back({5'd14, 32'hD0D0_0014});
            end else if (c == 5) begin
                lu_valid = 1'b0;
            end else if (c == 6) begin
                syscallw = 1'b0;
            end
            #1;
            checks++;
            if (stall_wb !== (c <= 5)) begin
                errors++;
                $display("FAIL drain_stall cycle %0d got %b required %b", c, stall_wb, c <= 5);
            end
            if (c == 5) begin
                checks++;
                if (rf_we !== 1'b1 || rf_wa !== 5'd14) begin
                    errors++;
                    $display("FAIL drain_bypass got we=%b wa=%0d required 1 14", rf_we, rf_wa);
                end
            end
        end
        idle_inputs();
        step();
    endtask

    task automatic test_reg_zero();
        regwritew = 1'b1; writeregw = 5'd0; resultw = 32'hDEAD_0000;
        lu_valid = 1'b1; lu_reg = 5'd0; lu_data = 32'hBEEF_0000;
        #1;
        checks++;
        if (lu_ready !== 1'b1 || pend_hazard !== 1'b0) begin
            errors++;
            $display("FAIL zero_accept got rdy=%b hz=%b required 1 0", lu_ready, pend_hazard);
        end
        step();
        idle_inputs();
        #1;
        checks++;
        if (rf_we !== 1'b0 || pend_hazard !== 1'b0 || lu_ready !== 1'b1) begin
            errors++;
            $display("FAIL zero_write got we=%b hz=%b rdy=%b required 0 0 1", rf_we, pend_hazard, lu_ready);
        end
        step();
        checks++;
        if (rf_we !== 1'b0) begin
            errors++;
            $display("FAIL zero_fifo got we=%b required 0", rf_we);
        end
    endtask

    initial begin
        test_reset();
        test_bypass();
        test_starve();
        test_wb_priority();
        test_drain();
        test_reg_zero();
        step(); step();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL missing_writes got %0d outstanding required 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
